// File: rtl/rcn2avalon.sv
// rcn2avalon: RCN ring slave bridge replaying window hits as single Avalon-MM transactions.
// Optional watchdog: define RCN2AVALON_TIMEOUT_EN to abort stuck accesses with data 32'hDEADDEAD.
module rcn2avalon #(
  parameter logic [21:0] ADDR_BASE = 22'h000000,
  parameter logic [21:0] ADDR_MASK = 22'h3F0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  output logic [21:0] av_address,
  output logic        av_write,
  output logic        av_read,
  output logic [3:0]  av_byteenable,
  output logic [31:0] av_writedata,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  input  logic        av_readdatavalid
);
  typedef enum logic [1:0] {IDLE, AV_REQ, RD_WAIT, RESP} state_t;
  state_t state_q;
  logic [68:0] rin_q, rout_q;
  logic wr_q;
  logic [5:0] id_q;
  logic [3:0] mask_q;
  logic [21:0] addr_q;
  logic [1:0] seq_q;
  logic [31:0] data_q;
  logic av_read_q, av_write_q;
  logic [21:0] av_address_q;
  logic [3:0] av_byteenable_q;
  logic [31:0] av_writedata_q;
  logic req_hit, accept, rd_done, timeout, cmpl;
  logic [31:0] cmpl_data;
  logic [68:0] resp;
  assign req_hit = rin_q[68] && rin_q[67] && ((rin_q[55:34] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign accept = state_q == AV_REQ && !av_waitrequest;
  assign rd_done = av_readdatavalid && !wr_q && (accept || state_q == RD_WAIT);
  assign cmpl = (accept && wr_q) || rd_done || timeout;
  assign cmpl_data = (accept && wr_q) ? data_q : rd_done ? av_readdata : 32'hDEADDEAD;
  assign resp = {2'b10, wr_q, id_q, mask_q, addr_q, seq_q, cmpl ? cmpl_data : data_q};
`ifdef RCN2AVALON_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign timeout = cnt_q == 16'hFFFF;
  always_ff @(posedge clk)
    cnt_q <= (rst || cmpl || accept || !(state_q == AV_REQ || state_q == RD_WAIT)) ? '0 : cnt_q + 16'd1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rin_q <= '0;
      rout_q <= '0;
      {wr_q, id_q, mask_q, addr_q, seq_q, data_q} <= '0;
      av_read_q <= 1'b0;
      av_write_q <= 1'b0;
      av_address_q <= '0;
      av_byteenable_q <= '0;
      av_writedata_q <= '0;
    end else begin
      rin_q <= rcn_in;
      rout_q <= rin_q;
      case (state_q)
        IDLE: if (req_hit) begin
          rout_q <= '0;
          {wr_q, id_q, mask_q, addr_q, seq_q, data_q} <= rin_q[66:0];
          av_write_q <= rin_q[66];
          av_read_q <= !rin_q[66];
          av_address_q <= rin_q[55:34] & ~ADDR_MASK;
          av_byteenable_q <= rin_q[59:56];
          av_writedata_q <= rin_q[31:0];
          state_q <= AV_REQ;
        end
        AV_REQ, RD_WAIT: begin
          if (accept || timeout) begin
            av_write_q <= 1'b0;
            av_read_q <= 1'b0;
          end
          // a completion meeting an empty slot is inserted on the same edge
          if (cmpl) begin
            data_q <= cmpl_data;
            state_q <= rin_q[68] ? RESP : IDLE;
            if (!rin_q[68]) rout_q <= resp;
          end else if (accept) state_q <= RD_WAIT;
        end
        default: if (!rin_q[68]) begin
          rout_q <= resp;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign rcn_out = rout_q;
  assign av_address = av_address_q;
  assign av_write = av_write_q;
  assign av_read = av_read_q;
  assign av_byteenable = av_byteenable_q;
  assign av_writedata = av_writedata_q;
endmodule

// File: tb/tb_rcn2avalon.sv
// tb_rcn2avalon: vector table, directed corner sequences and a randomized ring/Avalon run against a transaction model.
module tb_rcn2avalon;
  localparam logic [21:0] MASK = 22'h3F0000;
  logic clk = 0, rst = 1;
  logic [68:0] rcn_in = '0, rcn_out;
  logic [21:0] av_address;
  logic av_write, av_read;
  logic [3:0] av_byteenable;
  logic [31:0] av_writedata;
  logic av_waitrequest = 0;
  logic [31:0] av_readdata = '0;
  logic av_readdatavalid = 0;
  int checks = 0, errors = 0, rd_hi = 0, wr_hi = 0, n, r0, w0;
  bit both_seen = 0, quiet;

  rcn2avalon dut (
    .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
    .av_address(av_address), .av_write(av_write), .av_read(av_read),
    .av_byteenable(av_byteenable), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (av_read) rd_hi++;
    if (av_write) wr_hi++;
    if (av_read && av_write) both_seen = 1;
  end

  typedef struct {
    logic [68:0] in;
    logic [68:0] out;
    bit hit;
  } vec_t;
  vec_t tab[6];
  logic [68:0] t[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [68:0] req(input logic wr, input logic [5:0] id, input logic [3:0] m,
                                      input logic [21:0] a, input logic [1:0] s, input logic [31:0] d);
    return {2'b11, wr, id, m, a, s, d};
  endfunction

  function automatic logic [68:0] resp(input logic wr, input logic [5:0] id, input logic [3:0] m,
                                       input logic [21:0] a, input logic [1:0] s, input logic [31:0] d);
    return {2'b10, wr, id, m, a, s, d};
  endfunction

  function automatic logic [68:0] to_resp(input logic [68:0] r, input logic [31:0] d);
    return {2'b10, r[66:32], d};
  endfunction

  function automatic bit is_hit(input logic [68:0] r);
    return r[68] && r[67] && ((r[55:34] & MASK) == 22'h0);
  endfunction

  function automatic logic [68:0] rnd_slot();
    logic [95:0] r = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: return {1'b0, r[67:0]};
      1: return {2'b11, r[66:56], 6'h00, r[49:34], r[33:0]};
      2: return {2'b11, r[66:56], r[55:51], 1'b1, r[49:34], r[33:0]};
      default: return {2'b10, r[66:0]};
    endcase
  endfunction

  task automatic wait_resp(input string nm, input logic [68:0] e);
    for (int i = 0; i < 40 && !rcn_out[68]; i++) tick();
    chk(nm, rcn_out, e);
  endtask

  logic [68:0] prev_in, cur, x, exp_o;
  bit busy, strb, waiting, ready, wreq_r, rdv_now;
  int rdv_cd;
  logic [31:0] rword, rdata_m;

  initial begin
    repeat (3) tick();
    chk("rst_ring", rcn_out, '0);
    chk("rst_avalon", {av_read, av_write, av_address, av_byteenable, av_writedata}, '0);
    rst = 0;
    tick();

    tab[0] = '{req(1, 6'h01, 4'hF, 22'h010000, 0, 32'hAAAA5555), req(1, 6'h01, 4'hF, 22'h010000, 0, 32'hAAAA5555), 0};
    tab[1] = '{req(0, 6'h02, 4'h1, 22'h3FFFFF, 1, 32'h01234567), req(0, 6'h02, 4'h1, 22'h3FFFFF, 1, 32'h01234567), 0};
    tab[2] = '{resp(0, 6'h03, 4'h2, 22'h000004, 2, 32'h89ABCDEF), resp(0, 6'h03, 4'h2, 22'h000004, 2, 32'h89ABCDEF), 0};
    tab[3] = '{{2'b01, 1'b1, 6'h05, 4'h3, 22'h000008, 2'd1, 32'h0BADF00D}, {2'b01, 1'b1, 6'h05, 4'h3, 22'h000008, 2'd1, 32'h0BADF00D}, 0};
    tab[4] = '{req(1, 6'h06, 4'h3, 22'h00FFFF, 3, 32'hA5A5F0F0), '0, 1};
    tab[5] = '{req(1, 6'h07, 4'h1, 22'h000000, 0, 32'h00000001), '0, 1};
    foreach (tab[i]) begin
      rcn_in = tab[i].in;
      tick();
      rcn_in = '0;
      tick();
      chk($sformatf("vec%0d_ring", i), rcn_out, tab[i].out);
      chk($sformatf("vec%0d_strobe", i), {av_write, av_read}, tab[i].hit ? 2'b10 : 2'b00);
      if (tab[i].hit) begin
        chk($sformatf("vec%0d_addr", i), av_address, tab[i].in[55:34] & ~MASK);
        tick();
        chk($sformatf("vec%0d_resp", i), rcn_out, to_resp(tab[i].in, tab[i].in[31:0]));
      end
      tick();
      tick();
    end

    rcn_in = req(1, 6'h3F, 4'hF, 22'h000010, 2, 32'h12345678);
    tick();
    rcn_in = '0;
    tick();
    chk("wr_slot", rcn_out, '0);
    chk("wr_strobe", {av_write, av_read, av_address, av_byteenable, av_writedata}, {1'b1, 1'b0, 22'h000010, 4'hF, 32'h12345678});
    tick();
    chk("wr_resp", rcn_out, resp(1, 6'h3F, 4'hF, 22'h000010, 2, 32'h12345678));
    chk("wr_drop", av_write, 0);
    tick();

    av_waitrequest = 1;
    rcn_in = req(0, 6'h0A, 4'h5, 22'h000020, 3, 32'h0);
    tick();
    rcn_in = '0;
    tick();
    chk("rd_slot", rcn_out, '0);
    chk("rd_strobe", {av_read, av_address, av_byteenable}, {1'b1, 22'h000020, 4'h5});
    n = 0;
    repeat (3) begin
      n += int'(av_read);
      tick();
    end
    av_waitrequest = 0;
    n += int'(av_read);
    tick();
    chk("rd_hold", n, 4);
    chk("rd_drop", av_read, 0);
    tick();
    av_readdatavalid = 1;
    av_readdata = 32'hCAFEF00D;
    tick();
    av_readdatavalid = 0;
    wait_resp("rd_resp", resp(0, 6'h0A, 4'h5, 22'h000020, 3, 32'hCAFEF00D));
    tick();

    r0 = rd_hi;
    w0 = wr_hi;
    rcn_in = req(0, 6'h21, 4'hF, 22'h000030, 1, 32'h0);
    tick();
    rcn_in = '0;
    tick();
    tick();
    rcn_in = req(1, 6'h22, 4'hF, 22'h000031, 2, 32'h55AA55AA);
    tick();
    rcn_in = '0;
    tick();
    chk("busy_pass", rcn_out, req(1, 6'h22, 4'hF, 22'h000031, 2, 32'h55AA55AA));
    tick();
    av_readdatavalid = 1;
    av_readdata = 32'h13579BDF;
    tick();
    av_readdatavalid = 0;
    wait_resp("busy_resp", resp(0, 6'h21, 4'hF, 22'h000030, 1, 32'h13579BDF));
    chk("busy_one_rd", rd_hi - r0, 1);
    chk("busy_no_wr", wr_hi - w0, 0);
    tick();

    foreach (t[k]) t[k] = req(1, 6'(k), 4'hF, 22'h100000 + 22'(k), 0, $urandom());
    rcn_in = req(1, 6'h07, 4'hC, 22'h000044, 0, 32'hFEEDBEEF);
    tick();
    for (int k = 0; k < 6; k++) begin
      rcn_in = t[k];
      tick();
      if (k == 0) chk("ring_slot", rcn_out, '0);
      else chk($sformatf("ring_pass%0d", k - 1), rcn_out, t[k - 1]);
    end
    rcn_in = '0;
    tick();
    chk("ring_pass5", rcn_out, t[5]);
    tick();
    chk("ring_resp", rcn_out, resp(1, 6'h07, 4'hC, 22'h000044, 0, 32'hFEEDBEEF));
    tick();
    chk("ring_after", rcn_out, '0);

    av_waitrequest = 1;
    rcn_in = req(0, 6'h09, 4'hF, 22'h000050, 0, 32'h0);
    tick();
    rcn_in = '0;
    tick();
    tick();
    chk("pre_rst_rd", av_read, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_rd", av_read, 0);
    chk("midrst_ring", rcn_out, '0);
    av_waitrequest = 0;
    av_readdatavalid = 1;
    av_readdata = 32'h77777777;
    tick();
    av_readdatavalid = 0;
    quiet = 1;
    repeat (10) begin
      tick();
      if (rcn_out != '0 || av_read || av_write) quiet = 0;
    end
    chk("midrst_quiet", quiet, 1);

    prev_in = rcn_in;
    cur = '0;
    busy = 0; strb = 0; waiting = 0; ready = 0; rdv_cd = 0; rdata_m = '0;
    for (int c = 0; c < 3000; c++) begin
      x = rnd_slot();
      wreq_r = ($urandom_range(0, 2) == 0);
      rdv_now = 0;
      rword = $urandom();
      if (strb && !wreq_r && !cur[66]) begin
        rdv_cd = $urandom_range(0, 3);
        rdv_now = rdv_cd == 0;
      end else if (waiting && rdv_cd > 0) begin
        rdv_cd--;
        rdv_now = rdv_cd == 0;
      end
      rcn_in = x;
      av_waitrequest = wreq_r;
      av_readdatavalid = rdv_now;
      av_readdata = rword;
      exp_o = prev_in;
      if (!busy) begin
        if (is_hit(prev_in)) begin
          exp_o = '0;
          busy = 1;
          strb = 1;
          ready = 0;
          cur = prev_in;
        end
      end else begin
        if (strb && !wreq_r) begin
          strb = 0;
          if (cur[66]) begin
            ready = 1;
            rdata_m = cur[31:0];
          end else if (rdv_now) begin
            ready = 1;
            rdata_m = rword;
          end else waiting = 1;
        end else if (waiting && rdv_now) begin
          waiting = 0;
          ready = 1;
          rdata_m = rword;
        end
        if (ready && !prev_in[68]) begin
          exp_o = to_resp(cur, rdata_m);
          busy = 0;
          ready = 0;
        end
      end
      prev_in = x;
      tick();
      chk("rnd_ring", rcn_out, exp_o);
      chk("rnd_avalon",
          {av_read, av_write, (av_read || av_write) ? {av_address, av_byteenable, av_writedata} : 58'b0},
          {strb && !cur[66], strb && cur[66], strb ? {cur[55:34] & ~MASK, cur[59:56], cur[31:0]} : 58'b0});
    end
    rcn_in = '0;
    av_waitrequest = 0;
    av_readdatavalid = 0;
    repeat (5) tick();

`ifdef RCN2AVALON_TIMEOUT_EN
    rst = 1;
    tick();
    rst = 0;
    av_waitrequest = 1;
    rcn_in = req(0, 6'h11, 4'hF, 22'h000040, 1, 32'h0);
    tick();
    rcn_in = '0;
    for (int i = 0; i < 70000 && !rcn_out[68]; i++) tick();
    chk("timeout_resp", rcn_out, resp(0, 6'h11, 4'hF, 22'h000040, 1, 32'hDEADDEAD));
    chk("timeout_drop", av_read, 0);
    av_waitrequest = 0;
`endif

    chk("strobe_exclusive", both_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rcn2avalon.md
Name: rcn2avalon

Overview:
- RCN bus slave bridge. Sits on the RCN ring downstream of the Avalon-to-RCN master bridge.
- Removes request slots that hit its address window and replays each one as a single Avalon-MM master transaction.
- Re-inserts the completion onto the ring as a response addressed to the originating master id/seq.
- Single outstanding transaction; non-accepted traffic passes through with one cycle of latency.

Parameters:
- ADDR_BASE, 22'h000000, word-address base of the window (compared against rcn addr[23:2]).
- ADDR_MASK, 22'h3F0000, bits of the address compared for a hit; the remaining bits are offset.

Ports:
- clk  input  1  single clock for ring and Avalon side.
- rst  input  1  synchronous, active-high reset.
- rcn_in  input  69  ring in: {valid, pending, wr, id[5:0], mask[3:0], addr[23:2], seq[1:0], data[31:0]}.
- rcn_out  output  69  ring out, same format, registered.
- av_address  output  22  word address, registered = (rin addr & ~ADDR_MASK).
- av_write  output  1  Avalon write strobe, registered.
- av_read  output  1  Avalon read strobe, registered.
- av_byteenable  output  4  equals request mask.
- av_writedata  output  32  equals request data.
- av_waitrequest  input  1  slave stall.
- av_readdata  input  32  read data.
- av_readdatavalid  input  1  read data strobe.

Behaviour:
- Reset: all registers clear synchronously. rin=0, rout=0, av_read=av_write=0, av_address/byteenable/writedata=0, state=IDLE. A reset mid-transaction drops it silently; no response is issued.
- Input register: rin <= rcn_in every cycle. req_hit = rin[68] && rin[67] && ((rin[55:34] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)).
- IDLE:
  - req_hit: rout <= 0 (slot removed).
  - Latch wr, id, seq, mask, addr, data.
  - Drive av_write=wr or av_read=!wr next cycle. Go to AV_REQ.
  - Otherwise rout <= rin.
- AV_REQ:
  - Hold strobe, address, byteenable and writedata stable while av_waitrequest=1.
  - Edge with av_waitrequest=0: drop the strobe.
  - Write: build the response and go to RESP.
  - Read: go to RD_WAIT.
  - readdatavalid sampled in the same cycle as the accept edge is captured, and the block goes directly to RESP.
- RD_WAIT: at the edge with av_readdatavalid=1, capture av_readdata into the response register and go to RESP.
- RESP:
  - Response = {1, 0, wr, id, mask, addr, seq, data}. Data is the read data for reads and the original write data for writes.
  - At an edge where rin[68]==0 (empty slot): rout <= response, go to IDLE.
  - Otherwise rout <= rin; keep waiting.
- Outside IDLE:
  - Matching requests are NOT accepted and pass through unchanged (rout <= rin) so they circulate.
  - Responses and non-hit traffic always pass through.
- Latency: request present on rcn_in at cycle N gives rin at N+1, strobe at N+2. Write with zero waitrequest: response on rcn_out at N+3, provided an empty slot arrives.
- Back-to-back hits: the second hit circulates until the bridge returns to IDLE; it is never dropped.
- Strobes: av_read and av_write are never both 1. At most one Avalon access is outstanding.

Optional Feature:
- Macro RCN2AVALON_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in AV_REQ and RD_WAIT and clears on every state change.
  - When it reaches 16'hFFFF, the block drops the strobe and goes to RESP with data 32'hDEADDEAD.
  - A late av_readdatavalid arriving in IDLE is ignored.
- Undefined: no counter; the bridge waits indefinitely.

Test Plan:
- Write hit: rcn_in request wr=1, id=6'h3F, seq=2, mask=4'hF, addr=22'h000010, data=32'h12345678, waitrequest=0 -> av_write one cycle with av_address=22'h000010, av_writedata=32'h12345678; the next cycle rcn_out={1,0,1,3F,F,000010,2,12345678}; the request slot shows 0 on rcn_out.
- Read hit with waitrequest held 3 cycles and readdatavalid 2 cycles after accept, readdata=32'hCAFEF00D -> av_read held 4 cycles; response with pending=0, wr=0, data=32'hCAFEF00D, same id/seq.
- Miss: addr=22'h010000 with default params -> rcn_out equals rcn_in delayed 2 cycles; no Avalon strobe.
- Busy: second hit arrives while in RD_WAIT -> second hit appears unchanged on rcn_out; only one av_read is issued.
- Full ring: all rin slots valid during RESP for 5 cycles -> response is held and inserted at the first empty slot; pass-through traffic is intact.
- Reset asserted during AV_REQ -> next cycle av_read=0, rcn_out=0, state IDLE. With RCN2AVALON_TIMEOUT_EN and waitrequest stuck high: response data 32'hDEADDEAD after 65535 cycles.
